// File: rtl/vehicle_sensor_qualifier.sv
`default_nettype none
// ============================================================================
// Module   : vehicle_sensor_qualifier
// Purpose  : Synchronise, debounce and hold-stretch an inductive-loop call;
//            fail safe on a stuck loop and count qualified arrivals.
// Revision : 1.0  initial release
// ============================================================================
module vehicle_sensor_qualifier #(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int DEBOUNCE_CYC = 16,
   parameter int HOLD_SEC     = 2,
   parameter int STUCK_SEC    = 120,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             loop_raw,
   input  logic             stat_clr,
   output logic             sensor,
   output logic             present,
   output logic             fault,
   output logic [CNT_W-1:0] arrivals
);

   localparam int c_DEB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int c_SEC_W   = $clog2(CLK_FREQ + 1);
   localparam int c_HOLD_W  = $clog2(HOLD_SEC + 1);
   localparam int c_STUCK_W = $clog2(STUCK_SEC + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALL  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   logic                 r_s1;
   logic                 r_s2;
   logic [c_DEB_W-1:0]   r_deb_cnt;
   logic                 r_present;
   logic [c_SEC_W-1:0]   r_sec_cnt;
   logic [c_STUCK_W-1:0] r_stuck_cnt;
   logic [c_HOLD_W-1:0]  r_hold_cnt;
   logic [CNT_W-1:0]     r_arrivals;
   logic                 r_fault;
   logic                 r_sensor;
   state_t               r_state;

   state_t               w_next;
   logic                 w_tick;
   logic                 w_arrive;
   logic                 w_set_fault;
   logic                 w_stuck_clr;
   logic                 w_stuck_inc;
   logic                 w_hold_load;
   logic                 w_hold_dec;

   assign sensor   = r_sensor;
   assign present  = r_present;
   assign fault    = r_fault;
   assign arrivals = r_arrivals;

   assign w_tick = (r_sec_cnt == c_SEC_W'(CLK_FREQ - 1));

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_deb_cnt <= '0;
         r_present <= 1'b0;
         r_sec_cnt <= '0;
      end else begin
         r_s1 <= loop_raw;
         r_s2 <= r_s1;
         // Any cycle where s2 agrees with the debounced level restarts the count.
         if (r_s2 != r_present) begin
            if (r_deb_cnt == c_DEB_W'(DEBOUNCE_CYC - 1)) begin
               r_present <= ~r_present;
               r_deb_cnt <= '0;
            end else begin
               r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
            end
         end else begin
            r_deb_cnt <= '0;
         end
         r_sec_cnt <= w_tick ? '0 : r_sec_cnt + c_SEC_W'(1);
      end
   end

   always_comb begin
      w_next      = r_state;
      w_arrive    = 1'b0;
      w_set_fault = 1'b0;
      w_stuck_clr = 1'b0;
      w_stuck_inc = 1'b0;
      w_hold_load = 1'b0;
      w_hold_dec  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_present) begin
               w_next      = ST_CALL;
               w_arrive    = 1'b1;
               w_stuck_clr = 1'b1;
            end
         end
         ST_CALL: begin
            w_stuck_inc = w_tick;
            if (w_tick && (r_stuck_cnt == c_STUCK_W'(STUCK_SEC - 1))) begin
               w_next      = ST_FAULT;
               w_set_fault = 1'b1;
            end else if (!r_present) begin
               w_next      = ST_HOLD;
               w_hold_load = 1'b1;
            end
         end
         ST_HOLD: begin
            if (r_present) begin
               w_next      = ST_CALL;
               w_arrive    = 1'b1;
               w_stuck_clr = 1'b1;
            end else if (w_tick) begin
               if (r_hold_cnt == c_HOLD_W'(1)) begin
                  w_next = ST_IDLE;
               end else begin
                  w_hold_dec = 1'b1;
               end
            end
         end
         ST_FAULT: begin
            if (!r_present) begin
               w_next      = ST_HOLD;
               w_hold_load = 1'b1;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state  <= ST_IDLE;
         r_sensor <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_sensor <= (w_next != ST_IDLE);
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_stuck_cnt <= '0;
         r_hold_cnt  <= '0;
         r_arrivals  <= '0;
         r_fault     <= 1'b0;
      end else begin
         if (w_stuck_clr) begin
            r_stuck_cnt <= '0;
         end else if (w_stuck_inc) begin
            r_stuck_cnt <= r_stuck_cnt + c_STUCK_W'(1);
         end

         if (w_hold_load) begin
            r_hold_cnt <= c_HOLD_W'(HOLD_SEC);
         end else if (w_hold_dec) begin
            r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
         end

         // A clear coinciding with an arrival leaves that arrival counted.
         if (w_arrive) begin
            if (stat_clr) begin
               r_arrivals <= CNT_W'(1);
            end else if (r_arrivals != {CNT_W{1'b1}}) begin
               r_arrivals <= r_arrivals + CNT_W'(1);
            end
         end else if (stat_clr) begin
            r_arrivals <= '0;
         end

         if (w_set_fault) begin
            r_fault <= 1'b1;
         end else if (stat_clr) begin
            r_fault <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vehicle_sensor_qualifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_vehicle_sensor_qualifier
// Purpose  : Scoreboard bench for vehicle_sensor_qualifier with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_vehicle_sensor_qualifier;

   localparam int CF = 50;
   localparam int DB = 4;
   localparam int HS = 2;
   localparam int SS = 5;
   localparam int CW = 8;
   localparam int ANY_HI = 1 << 30;

   logic          clk = 1'b0;
   logic          clear_n = 1'b0;
   logic          loop_raw = 1'b0;
   logic          stat_clr = 1'b0;
   logic          sensor;
   logic          present;
   logic          fault;
   logic [CW-1:0] arrivals;

   typedef struct {
      string name;
      logic  s;
      int    a;
      logic  f;
      int    lo;
      int    hi;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   vehicle_sensor_qualifier #(
      .CLK_FREQ    (CF),
      .DEBOUNCE_CYC(DB),
      .HOLD_SEC    (HS),
      .STUCK_SEC   (SS),
      .CNT_W       (CW)
   ) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .loop_raw(loop_raw),
      .stat_clr(stat_clr),
      .sensor  (sensor),
      .present (present),
      .fault   (fault),
      .arrivals(arrivals)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int expv);
      total++;
      if (got != expv) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, got, expv, cyc);
      end
   endtask

   task automatic expect_ev(input string nm, input logic s, input int a, input logic f,
                            input int lo, input int hi);
      exp_t e;
      e.name = nm;
      e.s    = s;
      e.a    = a;
      e.f    = f;
      e.lo   = lo;
      e.hi   = hi;
      sb.push_back(e);
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL timeout: %0d expected events outstanding, first %s", sb.size(), sb[0].name);
         sb.delete();
      end
   endtask

   // Monitor: any change on sensor/arrivals/fault is a presented output event.
   initial begin
      logic p_s, p_f;
      logic [CW-1:0] p_a;
      exp_t e;
      @(negedge clk);
      p_s = sensor;
      p_a = arrivals;
      p_f = fault;
      forever begin
         @(negedge clk);
         if (sensor !== p_s || arrivals !== p_a || fault !== p_f) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_event: got s=%0b a=%0d f=%0b at cyc %0d, expected no change",
                        sensor, arrivals, fault, cyc);
            end else begin
               e = sb.pop_front();
               if (sensor !== e.s || int'(arrivals) != e.a || fault !== e.f ||
                   cyc < e.lo || cyc > e.hi) begin
                  bad++;
                  $display("FAIL %s: got s=%0b a=%0d f=%0b cyc=%0d, expected s=%0b a=%0d f=%0b cyc=%0d..%0d",
                           e.name, sensor, arrivals, fault, cyc, e.s, e.a, e.f, e.lo, e.hi);
               end
            end
         end
         p_s = sensor;
         p_a = arrivals;
         p_f = fault;
      end
   end

   initial begin
      int t;
      int tl;
      // Reset held with the loop occupied: nothing may leak out.
      loop_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("reset_outputs", int'({sensor, present, fault, arrivals}), 0);
      end
      t = cyc;
      expect_ev("rise_after_reset", 1'b1, 1, 1'b0, t + 7, t + 7);
      clear_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("present_latency", int'(present), 1);
      chk("sensor_not_yet", int'(sensor), 0);

      // Hold release after the vehicle leaves.
      repeat (144) @(negedge clk);
      tl = cyc;
      loop_raw = 1'b0;
      expect_ev("hold_fall", 1'b0, 1, 1'b0, tl + 6 + 51, tl + 6 + 101);
      wait_empty(200);

      // Glitch shorter than the debounce window.
      repeat (5) @(negedge clk);
      loop_raw = 1'b1;
      repeat (3) @(negedge clk);
      loop_raw = 1'b0;
      repeat (20) @(negedge clk);
      chk("glitch_present", int'(present), 0);
      chk("glitch_sensor", int'(sensor), 0);
      chk("glitch_arrivals", int'(arrivals), 1);

      // Re-arrival inside HOLD: no sensor gap, one more arrival.
      t = cyc;
      expect_ev("rise2", 1'b1, 2, 1'b0, t + 7, t + 7);
      loop_raw = 1'b1;
      repeat (30) @(negedge clk);
      loop_raw = 1'b0;
      repeat (10) @(negedge clk);
      expect_ev("rearrival", 1'b1, 3, 1'b0, t + 47, t + 47);
      loop_raw = 1'b1;
      repeat (20) @(negedge clk);
      tl = cyc;
      loop_raw = 1'b0;
      expect_ev("rearrival_fall", 1'b0, 3, 1'b0, tl + 6 + 51, tl + 6 + 101);
      wait_empty(200);

      // Stuck loop: fault after STUCK_SEC ticks in CALL, then hold and clear.
      t = cyc;
      expect_ev("stuck_rise", 1'b1, 4, 1'b0, t + 7, t + 7);
      expect_ev("stuck_fault", 1'b1, 4, 1'b1, t + 7 + 201, t + 7 + 250);
      loop_raw = 1'b1;
      repeat (300) @(negedge clk);
      tl = cyc;
      loop_raw = 1'b0;
      expect_ev("stuck_fall", 1'b0, 4, 1'b1, tl + 6 + 51, tl + 6 + 101);
      wait_empty(200);
      chk("fault_sticky", int'(fault), 1);
      t = cyc;
      expect_ev("stat_clr", 1'b0, 0, 1'b0, t + 1, t + 1);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      wait_empty(10);

      // Saturation: 260 arrivals, mostly re-arrivals from HOLD.
      for (int k = 1; k <= 260; k++) begin
         t = cyc;
         if (k <= 255) expect_ev("sat_arrival", 1'b1, k, 1'b0, t + 7, t + 7);
         loop_raw = 1'b1;
         repeat (8) @(negedge clk);
         loop_raw = 1'b0;
         repeat (8) @(negedge clk);
      end
      chk("sat_arrivals", int'(arrivals), 255);
      chk("sat_sensor_held", int'(sensor), 1);
      t = cyc;
      expect_ev("clr_with_arrival", 1'b1, 1, 1'b0, t + 7, t + 7);
      loop_raw = 1'b1;
      repeat (6) @(negedge clk);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      @(negedge clk);
      tl = cyc;
      loop_raw = 1'b0;
      expect_ev("sat_fall", 1'b0, 1, 1'b0, tl + 6 + 51, tl + 6 + 101);
      wait_empty(200);

      // Asynchronous reset while in FAULT.
      t = cyc;
      expect_ev("fault2_rise", 1'b1, 2, 1'b0, t + 7, t + 7);
      expect_ev("fault2_set", 1'b1, 2, 1'b1, t + 7 + 201, t + 7 + 250);
      loop_raw = 1'b1;
      wait_empty(400);
      @(posedge clk);
      #3;
      expect_ev("async_reset", 1'b0, 0, 1'b0, 0, ANY_HI);
      clear_n = 1'b0;
      #1;
      chk("async_sensor", int'(sensor), 0);
      chk("async_fault", int'(fault), 0);
      loop_raw = 1'b0;
      repeat (3) @(negedge clk);
      clear_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_reset_sensor", int'(sensor), 0);
      chk("post_reset_arrivals", int'(arrivals), 0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
